// File: rtl/small_chirp_gen.sv
// small_chirp_gen: I/Q chirp source. The phase advances by a frequency word
// that ramps linearly from sample to sample. Sin/cos come from an iterative
// CORDIC that performs one micro-rotation per clock. Samples leave through a
// valid/ready handshake.
module small_chirp_gen #(
  parameter int WIDTH       = 16,
  parameter int PHASE_WIDTH = 24,   // at most 32 (angle table is held at 32 bits)
  parameter int CORDIC_ITER = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PHASE_WIDTH-1:0] freqStart,
  input  logic [PHASE_WIDTH-1:0] freqStep,
  input  logic [31:0]            numSamples,
  output logic                   busy,
  output logic                   done,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [WIDTH-1:0]       dataOutCos,
  output logic [WIDTH-1:0]       dataOutSin
);

  localparam int DW = WIDTH + 2;
  localparam int IW = $clog2(CORDIC_ITER + 1);
  localparam logic [IW-1:0] LAST_ITER = IW'(CORDIC_ITER - 1);

  // Start-vector magnitude, pre-divided by the CORDIC gain
  localparam longint K_L = (((64'sd1 <<< (WIDTH - 2)) - 64'sd1) * 64'sd607253
                            + 64'sd500000) / 64'sd1000000;
  // The two spare datapath bits serve as fraction (guard) bits, so the
  // vector runs at 4x the output scale and is rounded back on output.
  localparam logic signed [DW-1:0] K4 = DW'(K_L * 4);

  localparam int             SH   = 32 - PHASE_WIDTH;
  localparam logic [32:0]    HALF = (33'd1 << SH) >> 1;
  localparam logic signed [DW:0] RND  = (DW+1)'(2);
  localparam logic signed [DW:0] SMAX = (DW+1)'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [DW:0] SMIN = -SMAX;

  typedef enum logic [1:0] {IDLE, ROTATE, HOLD} state_t;

  state_t state, state_nxt;

  logic                          load_first, load_next, rot_en, out_load, hs, done_nxt;
  logic        [PHASE_WIDTH-1:0] phase, freq, step;
  logic        [31:0]            cnt;
  logic        [IW-1:0]          iter_p0;
  logic signed [DW-1:0]          x_p0, y_p0;
  logic signed [PHASE_WIDTH-1:0] z_p0;

  logic        [PHASE_WIDTH-1:0] ld_phase;
  logic signed [DW-1:0]          ld_x, ld_y;
  logic signed [PHASE_WIDTH-1:0] ld_z;
  logic signed [DW-1:0]          sx, sy, x_nxt, y_nxt;
  logic signed [PHASE_WIDTH-1:0] ang, z_nxt;

  // atan(2^-i) as a fraction of a full turn, scaled to 2^32, rounded to PHASE_WIDTH
  function automatic logic [PHASE_WIDTH-1:0] atan_lut(input int i);
    logic [31:0] t;
    logic [32:0] r;
    case (i)
      0:  t = 32'h2000_0000;  1:  t = 32'h12E4_051E;
      2:  t = 32'h09FB_385B;  3:  t = 32'h0511_11D4;
      4:  t = 32'h028B_0D43;  5:  t = 32'h0145_D7E1;
      6:  t = 32'h00A2_F61E;  7:  t = 32'h0051_7C55;
      8:  t = 32'h0028_BE53;  9:  t = 32'h0014_5F2F;
      10: t = 32'h000A_2F98;  11: t = 32'h0005_17CC;
      12: t = 32'h0002_8BE6;  13: t = 32'h0001_45F3;
      14: t = 32'h0000_A2FA;  15: t = 32'h0000_517D;
      16: t = 32'h0000_28BE;  17: t = 32'h0000_145F;
      18: t = 32'h0000_0A30;  19: t = 32'h0000_0518;
      20: t = 32'h0000_028C;  21: t = 32'h0000_0146;
      22: t = 32'h0000_00A3;  23: t = 32'h0000_0051;
      24: t = 32'h0000_0029;  25: t = 32'h0000_0014;
      26: t = 32'h0000_000A;  27: t = 32'h0000_0005;
      28: t = 32'h0000_0003;  29: t = 32'h0000_0001;
      30: t = 32'h0000_0001;  default: t = 32'h0000_0000;
    endcase
    r = ({1'b0, t} + HALF) >> SH;
    return PHASE_WIDTH'(r);
  endfunction

  // Drop the two guard bits with round-half-up, then clamp to the output range
  function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [DW-1:0] v);
    logic signed [DW:0] vx;
    logic signed [DW:0] r;
    vx = {v[DW-1], v};
    r  = (vx + RND) >>> 2;
    if (r > SMAX)      return SMAX[WIDTH-1:0];
    else if (r < SMIN) return SMIN[WIDTH-1:0];
    else               return r[WIDTH-1:0];
  endfunction

  assign busy = (state != IDLE);

  // Next-state and control strobes; stop overrides everything, including a handshake
  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    load_next  = 1'b0;
    rot_en     = 1'b0;
    out_load   = 1'b0;
    hs         = 1'b0;
    done_nxt   = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (numSamples != 32'd0) begin
              load_first = 1'b1;
              state_nxt  = ROTATE;
            end else begin
              done_nxt = 1'b1;
            end
          end
        end
        ROTATE: begin
          rot_en = 1'b1;
          if (iter_p0 == LAST_ITER) state_nxt = HOLD;
        end
        HOLD: begin
          if (!outValid) begin
            out_load = 1'b1;
          end else if (outReady) begin
            hs = 1'b1;
            if (cnt == 32'd1) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              load_next = 1'b1;
              state_nxt = ROTATE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register and handshake/status flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      outValid <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (stop || hs)    outValid <= 1'b0;
      else if (out_load) outValid <= 1'b1;
    end
  end

  // Starting vector for a new sample: quadrant picks the axis, residual goes to z
  always_comb begin
    ld_x     = '0;
    ld_y     = '0;
    ld_phase = load_first ? '0 : phase + freq;
    ld_z     = signed'({2'b00, ld_phase[PHASE_WIDTH-3:0]});
    case (ld_phase[PHASE_WIDTH-1 -: 2])
      2'd0:    ld_x = K4;
      2'd1:    ld_y = K4;
      2'd2:    ld_x = -K4;
      default: ld_y = -K4;
    endcase
  end

  // One CORDIC micro-rotation, direction chosen by the sign of the residual angle
  always_comb begin
    sx  = x_p0 >>> iter_p0;
    sy  = y_p0 >>> iter_p0;
    ang = signed'(atan_lut(int'(iter_p0)));
    if (!z_p0[PHASE_WIDTH-1]) begin
      x_nxt = x_p0 - sy;
      y_nxt = y_p0 + sx;
      z_nxt = z_p0 - ang;
    end else begin
      x_nxt = x_p0 + sy;
      y_nxt = y_p0 - sx;
      z_nxt = z_p0 + ang;
    end
  end

  // Phase/frequency accumulators, CORDIC vector and the held output sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase      <= '0;
      freq       <= '0;
      step       <= '0;
      cnt        <= '0;
      iter_p0    <= '0;
      x_p0       <= '0;
      y_p0       <= '0;
      z_p0       <= '0;
      dataOutCos <= '0;
      dataOutSin <= '0;
    end else begin
      if (load_first || load_next) begin
        iter_p0 <= '0;
        x_p0    <= ld_x;
        y_p0    <= ld_y;
        z_p0    <= ld_z;
        phase   <= ld_phase;
      end else if (rot_en) begin
        iter_p0 <= iter_p0 + IW'(1);
        x_p0    <= x_nxt;
        y_p0    <= y_nxt;
        z_p0    <= z_nxt;
      end
      if (load_first) begin
        freq <= freqStart;
        step <= freqStep;
        cnt  <= numSamples;
      end else if (load_next) begin
        freq <= freq + step;
      end
      if (hs) cnt <= cnt - 32'd1;
      if (out_load) begin
        dataOutCos <= round_sat(x_p0);
        dataOutSin <= round_sat(y_p0);
      end
    end
  end

endmodule

// File: tb/tb_small_chirp_gen.sv
// Testbench for small_chirp_gen: scoreboard of ideal cos/sin samples computed
// from the sweep rules, checked by a monitor on every output handshake.
module tb_small_chirp_gen;
  localparam int     WIDTH  = 16;
  localparam int     PW     = 24;
  localparam int     ITER   = 14;
  localparam real    AMP    = 16383.0;
  localparam real    TWO_PI = 6.283185307179586;
  localparam longint FULL   = longint'(1) << PW;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              outReady = 1'b0;
  logic [PW-1:0]     freqStart = '0;
  logic [PW-1:0]     freqStep = '0;
  logic [31:0]       numSamples = '0;
  logic              busy, done, outValid;
  logic [WIDTH-1:0]  dataOutCos, dataOutSin;

  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  int  hs_cnt = 0;
  int  hs_cyc[$];
  real exp_c[$];
  real exp_s[$];
  bit  rdy_rand = 1'b0;
  bit  rdy_val = 1'b1;
  real mc, ms, ec, es;

  small_chirp_gen #(.WIDTH(WIDTH), .PHASE_WIDTH(PW), .CORDIC_ITER(ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .freqStart(freqStart), .freqStep(freqStep), .numSamples(numSamples),
    .busy(busy), .done(done), .outValid(outValid), .outReady(outReady),
    .dataOutCos(dataOutCos), .dataOutSin(dataOutSin)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #2;
    outReady = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string name, input longint act, input longint expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic check_near(input string name, input real act, input real expv, input real tol);
    n_vec++;
    if ((act - expv > tol) || (expv - act > tol)) begin
      n_bad++;
      $display("FAIL %s: got %0.2f, expected %0.2f +-%0.1f", name, act, expv, tol);
    end
  endtask

  // Monitor: every accepted sample is compared against the next expected one
  initial forever begin
    @(negedge clk);
    if (!rst && outValid && outReady) begin
      hs_cnt++;
      hs_cyc.push_back(cyc);
      mc = real'($signed(dataOutCos));
      ms = real'($signed(dataOutSin));
      if (exp_c.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_sample: got cos=%0d sin=%0d, expected no sample", $signed(dataOutCos), $signed(dataOutSin));
      end else begin
        ec = exp_c.pop_front();
        es = exp_s.pop_front();
        check_near("cos", mc, ec, 4.0);
        check_near("sin", ms, es, 4.0);
        check_near("magnitude", $sqrt(mc * mc + ms * ms), AMP, 6.0);
      end
    end
    if (!rst && done) done_cnt++;
  end

  task automatic flush();
    exp_c.delete();
    exp_s.delete();
  endtask

  // Reference: sample k at phase sum of frequencies, frequency ramps by step
  task automatic push_sweep(input longint f0, input longint st, input int n);
    longint ph, fr;
    real    a;
    ph = 0;
    fr = f0;
    for (int k = 0; k < n; k++) begin
      a = TWO_PI * real'(ph) / real'(FULL);
      exp_c.push_back(AMP * $cos(a));
      exp_s.push_back(AMP * $sin(a));
      ph = (ph + fr) % FULL;
      fr = (fr + st) % FULL;
    end
  endtask

  task automatic run_start(input longint f0, input longint st, input int n);
    freqStart  = PW'(f0);
    freqStep   = PW'(st);
    numSamples = n;
    push_sweep(f0, st, n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k;
    k = 0;
    while ((busy || exp_c.size() != 0) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got busy=%0d pending=%0d after %0d cycles, expected idle", name, busy, exp_c.size(), k);
      flush();
    end
    cycles(2);
  endtask

  task automatic wait_hs(input string name, input int target, input int budget);
    int k;
    k = 0;
    while (hs_cnt < target && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= budget) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d handshakes, expected %0d", name, hs_cnt, target);
    end
  endtask

  initial begin
    int     lat, d0, h0, n;
    longint f0, st;
    logic [WIDTH-1:0] hc, hsn;

    cycles(3);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_valid", outValid, 0);
    check_eq("rst_cos", dataOutCos, 0);
    check_eq("rst_sin", dataOutSin, 0);
    rst = 1'b0;
    cycles(2);

    // Constant phase 0: latency, spacing, single done
    d0 = done_cnt;
    h0 = hs_cyc.size();
    run_start(0, 0, 4);
    lat = 0;
    while (!outValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("t1_latency", lat, ITER + 1);
    wait_idle("t1", 400);
    check_eq("t1_samples", hs_cyc.size() - h0, 4);
    if (hs_cyc.size() - h0 == 4)
      for (int k = 1; k < 4; k++)
        check_eq("t1_spacing", hs_cyc[h0 + k] - hs_cyc[h0 + k - 1], ITER + 2);
    check_eq("t1_done", done_cnt - d0, 1);
    check_eq("t1_busy", busy, 0);

    // Quarter-turn steps
    d0 = done_cnt;
    run_start(longint'(1) << 22, 0, 4);
    wait_idle("t2", 400);
    check_eq("t2_done", done_cnt - d0, 1);

    // Back-pressure in HOLD
    rdy_val = 1'b0;
    f0 = longint'($urandom) % FULL;
    st = longint'($urandom) % FULL;
    run_start(f0, st, 3);
    lat = 0;
    while (!outValid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    hc  = dataOutCos;
    hsn = dataOutSin;
    for (int k = 0; k < 10; k++) begin
      cycles(1);
      check_eq("t3_hold_valid", outValid, 1);
      check_eq("t3_hold_cos", dataOutCos, hc);
      check_eq("t3_hold_sin", dataOutSin, hsn);
    end
    rdy_val = 1'b1;
    wait_idle("t3", 400);

    // Long chirp with random back-pressure
    rdy_rand = 1'b1;
    d0 = done_cnt;
    run_start(0, 256, 2000);
    wait_idle("t4", 80000);
    check_eq("t4_done", done_cnt - d0, 1);

    // Short random sweeps, random back-pressure
    for (int r = 0; r < 3; r++) begin
      f0 = longint'($urandom) % FULL;
      st = longint'($urandom) % FULL;
      n  = $urandom_range(5, 20);
      run_start(f0, st, n);
      wait_idle("rand", 40 * n + 100);
    end
    rdy_rand = 1'b0;
    cycles(2);

    // Abort during the third rotation, then a fresh sweep
    d0 = done_cnt;
    h0 = hs_cnt;
    run_start(12345, 777, 6);
    wait_hs("t5", h0 + 2, 200);
    cycles(3);
    check_eq("t5_pre_busy", busy, 1);
    check_eq("t5_pre_valid", outValid, 0);
    stop = 1'b1;
    cycles(1);
    stop = 1'b0;
    check_eq("t5_stop_valid", outValid, 0);
    check_eq("t5_stop_busy", busy, 0);
    flush();
    cycles(20);
    check_eq("t5_no_done", done_cnt - d0, 0);
    run_start(12345, 777, 3);
    wait_idle("t5_fresh", 400);

    // Zero-length sweep
    numSamples = 0;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    check_eq("t6_zero_done", done, 1);
    check_eq("t6_zero_valid", outValid, 0);
    check_eq("t6_zero_busy", busy, 0);
    cycles(1);
    check_eq("t6_done_pulse", done, 0);

    // start while busy is ignored; inputs only matter at the start edge
    d0 = done_cnt;
    run_start(longint'(1) << 22, 0, 3);
    cycles(5);
    freqStart  = 24'h123456;
    freqStep   = 24'h000100;
    numSamples = 50;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    wait_idle("t6_busy_start", 400);
    check_eq("t6_busy_start_done", done_cnt - d0, 1);

    // Asynchronous reset during rotation
    h0 = hs_cnt;
    run_start(0, 0, 3);
    wait_hs("t6_rst", h0 + 1, 200);
    cycles(4);
    check_eq("t6_pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_rst_busy", busy, 0);
    check_eq("t6_rst_done", done, 0);
    check_eq("t6_rst_valid", outValid, 0);
    check_eq("t6_rst_cos", dataOutCos, 0);
    check_eq("t6_rst_sin", dataOutSin, 0);
    flush();
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(2);
    run_start(0, longint'(1) << 20, 3);
    wait_idle("t6_after_rst", 400);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
